reg_cmd_ctrl: RTL and testbench

- Command-decoder FSM upstream of the system register file.
- Consumes byte frames from the UART receiver and converts them into single-cycle write or read strobes on the register file port.
- Returns read data to the UART transmitter through a valid/busy handshake.
- Only the register-file command set is decoded here; other opcodes are rejected.

---
 rtl/reg_cmd_pkg.sv | 31 +++
 rtl/ctrl_timeout_cnt.sv | 39 +++
 rtl/reg_cmd_ctrl.sv | 166 ++++++++++++++++
 tb/tb_reg_cmd_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_cmd_pkg.sv
// reg_cmd_pkg
// Shared definitions for the register-file command decoder:
//   - default data/address widths and inter-byte timeout
//   - command opcodes CMD_WR / CMD_RD
//   - FSM state encoding
//   - helper telling which states are covered by the inter-byte timeout
package reg_cmd_pkg;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_ADDR_WIDTH     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_SEND
  } state_t;

  // Only the states that are waiting for the next RX byte of a frame are
  // timed; waiting on the register file or the transmitter is not.
  function automatic logic isTimedState(input state_t s);
    return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR);
  endfunction

endpackage

// File: rtl/ctrl_timeout_cnt.sv
// ctrl_timeout_cnt
// Loadable down-counter with an expire flag, used as the inter-byte
// watchdog of reg_cmd_ctrl.
// Ports:
//   CLK      in   system clock
//   RST      in   asynchronous reset, active-low
//   i_load   in   reload the counter to the full timeout window
//   i_en     in   count this cycle
//   o_expire out  window used up while enabled
module ctrl_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Loaded with TIMEOUT_CYCLES-1 so that the expire flag shows up in the
  // TIMEOUT_CYCLES-th enabled cycle after the last load.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= LOAD_VAL;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl
// Command decoder between the UART receiver/transmitter and the system
// register file. Frames:
//   write: 0xAA, ADDR, DATA  -> one-cycle WrEn with Address/WrData
//   read : 0xBB, ADDR        -> one-cycle RdEn, then the read value is sent
//                               back as a single TX byte
// Anything else is discarded with a one-cycle FRAME_ERR pulse.
// Optional build macro CTRL_TIMEOUT_EN adds an inter-byte timeout
// (TIMEOUT_CYCLES) for partially received frames.
// Ports:
//   CLK, RST            clock, asynchronous active-low reset
//   RX_P_DATA/RX_D_VLD  received byte and its one-cycle valid
//   WrEn/RdEn           register file write/read strobes
//   Address/WrData      register file address and write data
//   RdData/RdData_Valid register file read data and (sticky) valid level
//   TX_P_DATA/TX_D_VLD  byte to transmit and its one-cycle request
//   TX_Busy             transmitter busy
//   FRAME_ERR           one-cycle pulse per discarded frame or byte
module reg_cmd_ctrl
  import reg_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_Busy,
  output logic                  FRAME_ERR
);

  state_t r_state;
  logic   w_addr_ok;
  logic   w_expire;

  // An address byte is legal when no bit above the address field is set.
  assign w_addr_ok = (RX_P_DATA >> ADDR_WIDTH) == '0;

`ifdef CTRL_TIMEOUT_EN
  logic w_timed;

  // Every received byte restarts the window; leaving the timed states
  // keeps it parked at full length.
  assign w_timed = isTimedState(r_state);

  ctrl_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK      (CLK),
    .RST      (RST),
    .i_load   (RX_D_VLD || !w_timed),
    .i_en     (w_timed),
    .o_expire (w_expire)
  );
`else
  logic w_timeout_unused;

  // Keeps the timeout parameter referenced in builds without the counter.
  assign w_timeout_unused = (TIMEOUT_CYCLES != 0);
  assign w_expire         = 1'b0;
`endif

  // Frame decoder. Strobes and FRAME_ERR default low every cycle so each is
  // a single-cycle pulse. RD_WAIT ignores RdData_Valid while RdEn is still
  // high, because the register file keeps valid asserted from the previous
  // read and only refreshes RdData after it has seen the new RdEn.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      TX_D_VLD  <= 1'b0;
      FRAME_ERR <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == DATA_WIDTH'(CMD_WR)) begin
              r_state <= WR_ADDR;
            end else if (RX_P_DATA == DATA_WIDTH'(CMD_RD)) begin
              r_state <= RD_ADDR;
            end else begin
              FRAME_ERR <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (RX_D_VLD) begin
            if (w_addr_ok) begin
              Address <= RX_P_DATA[ADDR_WIDTH-1:0];
              r_state <= WR_DATA;
            end else begin
              FRAME_ERR <= 1'b1;
              r_state   <= IDLE;
            end
          end else if (w_expire) begin
            FRAME_ERR <= 1'b1;
            r_state   <= IDLE;
          end
        end
        WR_DATA: begin
          if (RX_D_VLD) begin
            WrData  <= RX_P_DATA;
            WrEn    <= 1'b1;
            r_state <= IDLE;
          end else if (w_expire) begin
            FRAME_ERR <= 1'b1;
            r_state   <= IDLE;
          end
        end
        RD_ADDR: begin
          if (RX_D_VLD) begin
            if (w_addr_ok) begin
              Address <= RX_P_DATA[ADDR_WIDTH-1:0];
              RdEn    <= 1'b1;
              r_state <= RD_WAIT;
            end else begin
              FRAME_ERR <= 1'b1;
              r_state   <= IDLE;
            end
          end else if (w_expire) begin
            FRAME_ERR <= 1'b1;
            r_state   <= IDLE;
          end
        end
        RD_WAIT: begin
          if (RX_D_VLD) begin
            FRAME_ERR <= 1'b1;
          end
          if (!RdEn && RdData_Valid) begin
            TX_P_DATA <= RdData;
            r_state   <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (RX_D_VLD) begin
            FRAME_ERR <= 1'b1;
          end
          if (!TX_Busy) begin
            TX_D_VLD <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// tb_reg_cmd_ctrl
// Self-checking bench for reg_cmd_ctrl: a table of single frames, a few
// hand-written multi-cycle sequences (busy transmitter, stale read valid,
// back-to-back frames, mid-frame reset, inter-byte timeout) and a block of
// random frames compared against a frame-level reference model.
// Build with CTRL_TIMEOUT_EN defined to exercise the 16-cycle timeout.
module tb_reg_cmd_ctrl;
  import reg_cmd_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] RX_P_DATA = '0;
  logic          RX_D_VLD = 1'b0;
  logic          WrEn;
  logic          RdEn;
  logic [AW-1:0] Address;
  logic [DW-1:0] WrData;
  logic [DW-1:0] RdData;
  logic          RdData_Valid;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_D_VLD;
  logic          TX_Busy = 1'b0;
  logic          FRAME_ERR;

  int checks = 0;
  int passes = 0;

  reg_cmd_ctrl #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_P_DATA    (RX_P_DATA),
    .RX_D_VLD     (RX_D_VLD),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .Address      (Address),
    .WrData       (WrData),
    .RdData       (RdData),
    .RdData_Valid (RdData_Valid),
    .TX_P_DATA    (TX_P_DATA),
    .TX_D_VLD     (TX_D_VLD),
    .TX_Busy      (TX_Busy),
    .FRAME_ERR    (FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  // Register file stand-in: one-cycle read latency, sticky read valid.
  logic [DW-1:0] rfMem [16];
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) rfMem[i] <= '0;
      RdData       <= '0;
      RdData_Valid <= 1'b0;
    end else begin
      if (WrEn) rfMem[Address] <= WrData;
      if (RdEn) begin
        RdData       <= rfMem[Address];
        RdData_Valid <= 1'b1;
      end
    end
  end

  // Event monitor: logs every strobe and counts strobe-shape violations
  // (overlapping WrEn/RdEn or any strobe lasting more than one cycle).
  logic [11:0] obsWr [$];
  logic [3:0]  obsRd [$];
  logic [7:0]  obsTx [$];
  int          obsErr = 0;
  int          violations = 0;
  logic        pWr = 1'b0, pRd = 1'b0, pTx = 1'b0;
  always @(negedge CLK) begin
    if (RST) begin
      if (WrEn) obsWr.push_back({Address, WrData});
      if (RdEn) obsRd.push_back(Address);
      if (TX_D_VLD) obsTx.push_back(TX_P_DATA);
      if (FRAME_ERR) obsErr++;
      if ((WrEn && RdEn) || (WrEn && pWr) || (RdEn && pRd) || (TX_D_VLD && pTx))
        violations++;
    end
    pWr = WrEn;
    pRd = RdEn;
    pTx = TX_D_VLD;
  end

  // Run-time bound for the whole test.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish (got running, required finished)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Presents one byte for exactly one sampling edge; returns 1 unit after
  // that edge so the registered response is already visible.
  task automatic sendByte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK);
    #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic waitTx(output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d  = '0;
    for (int k = 0; k < 60; k++) begin
      idle(1);
      if (TX_D_VLD) begin
        ok = 1'b1;
        d  = TX_P_DATA;
        break;
      end
    end
  endtask

  typedef struct {
    int         nb;
    logic [7:0] b0, b1, b2;
    logic       expWr, expRd, expErr;
    logic [3:0] expAddr;
    logic [7:0] expData;
  } vec_t;

  vec_t vecs [12];

  task automatic applyStimulus(input int idx, input vec_t v);
    logic [7:0] d;
    bit ok;
    sendByte(v.b0);
    if (v.nb > 1) sendByte(v.b1);
    if (v.nb > 2) sendByte(v.b2);
    checkOutput($sformatf("vec%0d_WrEn", idx), 32'(WrEn), 32'(v.expWr));
    checkOutput($sformatf("vec%0d_RdEn", idx), 32'(RdEn), 32'(v.expRd));
    checkOutput($sformatf("vec%0d_FRAME_ERR", idx), 32'(FRAME_ERR), 32'(v.expErr));
    checkOutput($sformatf("vec%0d_Address", idx), 32'(Address), 32'(v.expAddr));
    if (v.expWr) checkOutput($sformatf("vec%0d_WrData", idx), 32'(WrData), 32'(v.expData));
    if (v.expRd) begin
      waitTx(d, ok);
      checkOutput($sformatf("vec%0d_tx_seen", idx), 32'(ok), 32'd1);
      checkOutput($sformatf("vec%0d_TX_P_DATA", idx), 32'(d), 32'(v.expData));
    end
    idle(1);
  endtask

  // Frame-level reference model for the random block.
  logic [7:0]  modelMem [16];
  logic [11:0] expWr [$];
  logic [3:0]  expRd [$];
  logic [7:0]  expTx [$];
  int          expErr;

  initial begin
    logic [7:0] d;
    bit ok;
    int txEarly;
    int wrBase, rdBase, txBase, errBase;
    int errSeen;

    // Reset state
    idle(2);
    checkOutput("reset_outputs",
                32'({WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, FRAME_ERR}), 32'd0);
    RST = 1'b1;
    idle(1);

    // Single-frame table: {bytes, WrEn, RdEn, FRAME_ERR, Address, data}
    vecs[0]  = '{3, 8'hAA, 8'h05, 8'h3C, 1'b1, 1'b0, 1'b0, 4'h5, 8'h3C};
    vecs[1]  = '{1, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 4'h5, 8'h00};
    vecs[2]  = '{2, 8'hAA, 8'h20, 8'h00, 1'b0, 1'b0, 1'b1, 4'h5, 8'h00};
    vecs[3]  = '{3, 8'hAA, 8'h02, 8'h81, 1'b1, 1'b0, 1'b0, 4'h2, 8'h81};
    vecs[4]  = '{3, 8'hAA, 8'h0F, 8'hFF, 1'b1, 1'b0, 1'b0, 4'hF, 8'hFF};
    vecs[5]  = '{2, 8'hAA, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 4'hF, 8'h00};
    vecs[6]  = '{2, 8'hBB, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 4'h5, 8'h3C};
    vecs[7]  = '{2, 8'hBB, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 4'h5, 8'h00};
    vecs[8]  = '{1, 8'hAB, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 4'h5, 8'h00};
    vecs[9]  = '{2, 8'hBB, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0, 4'hF, 8'hFF};
    vecs[10] = '{3, 8'hAA, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00};
    vecs[11] = '{2, 8'hBB, 8'h02, 8'h00, 1'b0, 1'b1, 1'b0, 4'h2, 8'h81};
    for (int i = 0; i < 12; i++) applyStimulus(i, vecs[i]);

    // Read with the transmitter busy for 20 cycles; a byte arriving while
    // waiting is dropped without disturbing the pending response.
    TX_Busy = 1'b1;
    sendByte(8'hBB);
    sendByte(8'h05);
    checkOutput("busy_RdEn", 32'(RdEn), 32'd1);
    txEarly = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (TX_D_VLD) txEarly++;
    end
    sendByte(8'hAA);
    checkOutput("busy_drop_FRAME_ERR", 32'(FRAME_ERR), 32'd1);
    for (int i = 0; i < 14; i++) begin
      idle(1);
      if (TX_D_VLD) txEarly++;
    end
    checkOutput("busy_no_early_tx", 32'(txEarly), 32'd0);
    TX_Busy = 1'b0;
    idle(1);
    checkOutput("busy_TX_D_VLD", 32'(TX_D_VLD), 32'd1);
    checkOutput("busy_TX_P_DATA", 32'(TX_P_DATA), 32'h3C);
    idle(1);
    checkOutput("busy_TX_D_VLD_pulse", 32'(TX_D_VLD), 32'd0);

    // Stale read valid: the register file still shows the previous read.
    sendByte(8'hAA); sendByte(8'h03); sendByte(8'h77);
    checkOutput("stale_wr_WrEn", 32'(WrEn), 32'd1);
    sendByte(8'hBB); sendByte(8'h03);
    waitTx(d, ok);
    checkOutput("stale_tx_seen", 32'(ok), 32'd1);
    checkOutput("stale_TX_P_DATA", 32'(d), 32'h77);

    // Back-to-back: opcodes in the WrEn cycle and in the TX_D_VLD cycle.
    sendByte(8'hAA); sendByte(8'h01); sendByte(8'h11);
    sendByte(8'hBB); sendByte(8'h01);
    checkOutput("b2b_RdEn", 32'(RdEn), 32'd1);
    waitTx(d, ok);
    checkOutput("b2b_TX_P_DATA", 32'({7'd0, ok, d}), 32'h111);
    sendByte(8'hAA); sendByte(8'h09); sendByte(8'h5A);
    checkOutput("b2b_after_tx_WrEn", 32'({WrEn, Address, WrData}), 32'h195A);
    idle(1);

    // Reset between the ADDR and DATA bytes of a write.
    sendByte(8'hAA); sendByte(8'h07);
    #2;
    RST = 1'b0;
    #1;
    checkOutput("midreset_outputs",
                32'({WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, FRAME_ERR}), 32'd0);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b1;
    idle(1);
    sendByte(8'h44);
    checkOutput("midreset_no_write", 32'({WrEn, FRAME_ERR}), 32'b01);
    sendByte(8'hAA); sendByte(8'h07); sendByte(8'h55);
    checkOutput("midreset_next_write", 32'({WrEn, Address, WrData}), 32'h1755);
    sendByte(8'hBB); sendByte(8'h07);
    waitTx(d, ok);
    checkOutput("midreset_readback", 32'({7'd0, ok, d}), 32'h155);
    idle(1);

    // Random frames against the frame-level model, from a clean reset.
    RST = 1'b0;
    idle(1);
    RST = 1'b1;
    idle(1);
    for (int i = 0; i < 16; i++) modelMem[i] = '0;
    expErr  = 0;
    wrBase  = obsWr.size();
    rdBase  = obsRd.size();
    txBase  = obsTx.size();
    errBase = obsErr;
    for (int f = 0; f < 40; f++) begin
      int kind;
      logic [7:0] a, v;
      int busyCycles;
      kind = int'($urandom_range(0, 5));
      idle(int'($urandom_range(0, 3)));
      case (kind)
        0, 1: begin
          a = 8'($urandom_range(0, 15));
          v = 8'($urandom_range(0, 255));
          sendByte(CMD_WR); idle(int'($urandom_range(0, 3)));
          sendByte(a);      idle(int'($urandom_range(0, 3)));
          sendByte(v);
          expWr.push_back({a[3:0], v});
          modelMem[a[3:0]] = v;
        end
        2, 3: begin
          a = 8'($urandom_range(0, 15));
          busyCycles = int'($urandom_range(0, 8));
          TX_Busy = (busyCycles != 0);
          sendByte(CMD_RD); idle(int'($urandom_range(0, 3)));
          sendByte(a);
          idle(busyCycles);
          TX_Busy = 1'b0;
          waitTx(d, ok);
          checkOutput($sformatf("rand%0d_tx_seen", f), 32'(ok), 32'd1);
          expRd.push_back(a[3:0]);
          expTx.push_back(modelMem[a[3:0]]);
        end
        4: begin
          a = 8'($urandom_range(0, 255));
          if (a == CMD_WR || a == CMD_RD) a = 8'h12;
          sendByte(a);
          expErr++;
        end
        default: begin
          a = 8'($urandom_range(16, 255));
          sendByte($urandom_range(0, 1) != 0 ? CMD_WR : CMD_RD);
          idle(int'($urandom_range(0, 3)));
          sendByte(a);
          expErr++;
        end
      endcase
    end
    idle(2);
    checkOutput("rand_wr_count", 32'(obsWr.size() - wrBase), 32'(expWr.size()));
    for (int i = 0; i < expWr.size(); i++)
      if (wrBase + i < obsWr.size())
        checkOutput($sformatf("rand_wr%0d", i), 32'(obsWr[wrBase + i]), 32'(expWr[i]));
    checkOutput("rand_rd_count", 32'(obsRd.size() - rdBase), 32'(expRd.size()));
    for (int i = 0; i < expRd.size(); i++)
      if (rdBase + i < obsRd.size())
        checkOutput($sformatf("rand_rd%0d", i), 32'(obsRd[rdBase + i]), 32'(expRd[i]));
    checkOutput("rand_tx_count", 32'(obsTx.size() - txBase), 32'(expTx.size()));
    for (int i = 0; i < expTx.size(); i++)
      if (txBase + i < obsTx.size())
        checkOutput($sformatf("rand_tx%0d", i), 32'(obsTx[txBase + i]), 32'(expTx[i]));
    checkOutput("rand_frame_err_count", 32'(obsErr - errBase), 32'(expErr));

    // Partial frame followed by silence.
    sendByte(8'hAA);
    errSeen = 0;
`ifdef CTRL_TIMEOUT_EN
    for (int i = 1; i <= 40; i++) begin
      idle(1);
      if (FRAME_ERR) begin
        errSeen = i;
        break;
      end
    end
    checkOutput("timeout_latency", 32'(errSeen), 32'(TO));
    sendByte(8'h05);
    checkOutput("timeout_back_in_idle", 32'({WrEn, FRAME_ERR}), 32'b01);
`else
    for (int i = 0; i < 10000; i++) begin
      idle(1);
      if (FRAME_ERR) errSeen++;
    end
    checkOutput("no_timeout_pulse", 32'(errSeen), 32'd0);
    sendByte(8'h05);
    sendByte(8'h3C);
    checkOutput("no_timeout_frame_completes", 32'({WrEn, Address, WrData}), 32'h153C);
`endif
    idle(2);

    checkOutput("strobe_shape_violations", 32'(violations), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
